bcd_display_driver: RTL and testbench

Parametrised binary-to-decimal display engine for multi-digit common-cathode/anode 7-segment displays. It accepts a binary value through a load handshake and converts it to BCD with a sequential double-dabble engine, one bit per clock. It holds the converted digits and time-multiplexes them onto shared segment lines with a built-in scan prescaler. It replaces the fixed 8-bit, 3-digit display multiplexer and generalises width, digit count, scan rate, blanking and output polarity.

---
 rtl/bcd_display_driver_if.sv | 26 ++
 rtl/bcd_display_driver.sv | 161 ++++++++++++++++
 tb/tb_bcd_display_driver.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/bcd_display_driver_if.sv
// Load handshake and status bundle for bcd_display_driver.
interface bcd_display_driver_if #(
  parameter int unsigned WIDTH = 8
) ();
  logic [WIDTH-1:0] value;
  logic             load;
  logic             ready;
  logic             done;
  logic             overflow;

  modport master (
    output value,
    output load,
    input  ready,
    input  done,
    input  overflow
  );

  modport slave (
    input  value,
    input  load,
    output ready,
    output done,
    output overflow
  );
endinterface

// File: rtl/bcd_display_driver.sv
// Binary to BCD conversion (sequential double-dabble) feeding a time-multiplexed
// 7-segment display with prescaled digit scan, leading-zero blanking and overflow dashes.
module bcd_display_driver #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DIGITS     = 3,
  parameter int unsigned SCAN_DIV   = 300,
  parameter bit          BLANK_LZ   = 1'b1,
  parameter bit          ACTIVE_LOW = 1'b0
) (
  input  logic                hwclk,
  input  logic                rst_n,
  bcd_display_driver_if.slave bus,
  output logic [6:0]          segments,
  output logic [DIGITS-1:0]   enable
);
  localparam int unsigned BcdW = 4 * DIGITS;
  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam int unsigned PreW = $clog2(SCAN_DIV);
  localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {StIdle, StShift, StLatch} state_e;

  state_e            r_state, w_state_d;
  logic [WIDTH-1:0]  r_bin;
  logic [BcdW-1:0]   r_bcd, w_adj;
  logic              r_acc;
  logic [CntW-1:0]   r_cnt;
  logic [BcdW-1:0]   r_disp, w_disp_d;
  logic              r_ovf, w_ovf_d;
  logic [PreW-1:0]   r_presc, w_presc_d;
  logic [IdxW-1:0]   r_idx, w_idx_d;
  logic              w_tc;
  logic [6:0]        r_seg, w_seg_d;
  logic [DIGITS-1:0] r_en, w_en_d;
  logic [3:0]        w_nib;
  logic              w_hi_zero;

  // FSM state register
  always_ff @(posedge hwclk) begin
    if (!rst_n) r_state <= StIdle;
    else        r_state <= w_state_d;
  end

  // FSM next-state logic
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (bus.load) w_state_d = StShift;
      StShift: if (r_cnt == CntW'(1)) w_state_d = StLatch;
      StLatch: w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    bus.ready    = (r_state == StIdle);
    bus.done     = (r_state == StLatch);
    bus.overflow = r_ovf;
  end

  // Double-dabble correction: nibbles >= 5 get +3 before each shift
  always_comb begin
    w_adj = r_bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
    end
  end

  // Conversion datapath and display latch
  always_ff @(posedge hwclk) begin
    if (!rst_n) begin
      r_bin  <= '0;
      r_bcd  <= '0;
      r_acc  <= 1'b0;
      r_cnt  <= '0;
      r_disp <= '0;
      r_ovf  <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (bus.load) begin
            r_bin <= bus.value;
            r_bcd <= '0;
            r_acc <= 1'b0;
            r_cnt <= CntW'(WIDTH);
          end
        end
        StShift: begin
          r_bcd <= {w_adj[BcdW-2:0], r_bin[WIDTH-1]};
          r_bin <= r_bin << 1;
          // Any bit leaving the top nibble means the value needs more digits
          r_acc <= r_acc | w_adj[BcdW-1];
          r_cnt <= r_cnt - CntW'(1);
        end
        StLatch: begin
          r_disp <= r_bcd;
          r_ovf  <= r_acc;
        end
        default: ;
      endcase
    end
  end

  // Next scan position and the display contents it will show
  always_comb begin
    w_tc      = (r_presc == PreW'(SCAN_DIV - 1));
    w_presc_d = w_tc ? '0 : r_presc + PreW'(1);
    w_idx_d   = r_idx;
    if (w_tc) w_idx_d = (r_idx == IdxW'(DIGITS - 1)) ? '0 : r_idx + IdxW'(1);
    // Use the value being latched this cycle so a coinciding scan step shows new data
    w_disp_d  = (r_state == StLatch) ? r_bcd : r_disp;
    w_ovf_d   = (r_state == StLatch) ? r_acc : r_ovf;
    w_en_d    = DIGITS'(1) << w_idx_d;
  end

  // Segment decode with overflow dash and leading-zero blanking
  always_comb begin
    w_nib     = 4'd0;
    w_hi_zero = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (IdxW'(i) == w_idx_d) w_nib = w_disp_d[4*i +: 4];
      if (IdxW'(i) >= w_idx_d && w_disp_d[4*i +: 4] != 4'd0) w_hi_zero = 1'b0;
    end
    case (w_nib)
      4'd0:    w_seg_d = 7'h3F;
      4'd1:    w_seg_d = 7'h06;
      4'd2:    w_seg_d = 7'h5B;
      4'd3:    w_seg_d = 7'h4F;
      4'd4:    w_seg_d = 7'h66;
      4'd5:    w_seg_d = 7'h6D;
      4'd6:    w_seg_d = 7'h7D;
      4'd7:    w_seg_d = 7'h07;
      4'd8:    w_seg_d = 7'h7F;
      4'd9:    w_seg_d = 7'h6F;
      default: w_seg_d = 7'h00;
    endcase
    if (w_ovf_d)                                          w_seg_d = 7'h40;
    else if (BLANK_LZ && (w_idx_d != '0) && w_hi_zero)    w_seg_d = 7'h00;
  end

  // Prescaler, digit index and registered outputs; segments and enable move together
  always_ff @(posedge hwclk) begin
    if (!rst_n) begin
      r_presc <= '0;
      r_idx   <= '0;
      r_seg   <= 7'h3F;
      r_en    <= DIGITS'(1);
    end else begin
      r_presc <= w_presc_d;
      r_idx   <= w_idx_d;
      if (w_tc) begin
        r_seg <= w_seg_d;
        r_en  <= w_en_d;
      end
    end
  end

  assign segments = ACTIVE_LOW ? ~r_seg : r_seg;
  assign enable   = ACTIVE_LOW ? ~r_en  : r_en;
endmodule

// File: tb/tb_bcd_display_driver.sv
// Scoreboard bench: two instances (3-digit active-high, 2-digit active-low) share stimulus;
// expected digits are queued at each load and checked against the scanned outputs.
module tb_bcd_display_driver;
  localparam int unsigned W  = 8;
  localparam int unsigned SD = 4;

  logic       hwclk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] value = '0;
  logic       load  = 1'b0;
  logic [6:0] seg_a, seg_b;
  logic [2:0] en_a;
  logic [1:0] en_b;
  int unsigned cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;

  always #5 hwclk = ~hwclk;
  always @(posedge hwclk) cyc <= cyc + 1;

  bcd_display_driver_if #(.WIDTH(W)) bus_a ();
  bcd_display_driver_if #(.WIDTH(W)) bus_b ();
  assign bus_a.value = value;
  assign bus_a.load  = load;
  assign bus_b.value = value;
  assign bus_b.load  = load;

  bcd_display_driver #(.WIDTH(W), .DIGITS(3), .SCAN_DIV(SD), .BLANK_LZ(1'b1),
                       .ACTIVE_LOW(1'b0)) u_dut_a (
    .hwclk(hwclk), .rst_n(rst_n), .bus(bus_a), .segments(seg_a), .enable(en_a));

  bcd_display_driver #(.WIDTH(W), .DIGITS(2), .SCAN_DIV(SD), .BLANK_LZ(1'b1),
                       .ACTIVE_LOW(1'b1)) u_dut_b (
    .hwclk(hwclk), .rst_n(rst_n), .bus(bus_b), .segments(seg_b), .enable(en_b));

  typedef struct packed {
    logic [31:0]     cyc;
    logic            ovf_a;
    logic [2:0][6:0] seg_a;
    logic            ovf_b;
    logic [1:0][6:0] seg_b;
  } exp_t;

  exp_t q[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Wait for ready, present a value with load high and queue its expected result
  task automatic issue(input logic [7:0] v, input logic oa, input logic [6:0] a2, a1, a0,
                       input logic ob, input logic [6:0] b1, b0);
    exp_t e;
    int   n = 0;
    @(negedge hwclk);
    while (!bus_a.ready && n < 40) begin
      @(negedge hwclk);
      n++;
    end
    chk("ready_wait", bus_a.ready, 1'b1);
    value   = v;
    load    = 1'b1;
    e.cyc   = cyc;
    e.ovf_a = oa;
    e.seg_a = {a2, a1, a0};
    e.ovf_b = ob;
    e.seg_b = {b1, b0};
    q.push_back(e);
  endtask

  task automatic settle();
    repeat (W + 2 + 4 * SD + 2) @(negedge hwclk);
  endtask

  task automatic run(input logic [7:0] v, input logic oa, input logic [6:0] a2, a1, a0,
                     input logic ob, input logic [6:0] b1, b0);
    issue(v, oa, a2, a1, a0, ob, b1, b0);
    @(negedge hwclk);
    load = 1'b0;
    settle();
  endtask

  // Monitor: pops on done, then checks every scanned digit and slot length
  exp_t       cur, pend;
  logic       cur_valid = 1'b0;
  logic       act       = 1'b0;
  logic       rst_prev  = 1'b0;
  logic [2:0] pa, ea;
  logic [1:0] pb, eb;
  logic [6:0] sb;
  int         hold = 0;

  initial begin
    forever begin
      @(negedge hwclk);
      #1;
      ea = en_a;
      eb = ~en_b;
      sb = ~seg_b;
      if (rst_prev) begin
        chk("rst_ready", {bus_a.ready, bus_b.ready}, 2'b11);
        chk("rst_done", {bus_a.done, bus_b.done}, 2'b00);
        chk("rst_ovf", {bus_a.overflow, bus_b.overflow}, 2'b00);
        chk("rst_en_a", ea, 3'b001);
        chk("rst_en_b", eb, 2'b01);
        chk("rst_seg_a", seg_a, 7'h3F);
        chk("rst_seg_b", sb, 7'h3F);
        cur.ovf_a = 1'b0;
        cur.seg_a = {7'h00, 7'h00, 7'h3F};
        cur.ovf_b = 1'b0;
        cur.seg_b = {7'h00, 7'h3F};
        cur_valid = 1'b1;
        act       = 1'b0;
        hold      = 1;
        pa        = ea;
        pb        = eb;
      end else if (cur_valid) begin
        if (act) begin
          cur = pend;
          act = 1'b0;
          chk("ovf_a", bus_a.overflow, cur.ovf_a);
          chk("ovf_b", bus_b.overflow, cur.ovf_b);
        end
        if (bus_a.done || bus_b.done) begin
          chk("done_sync", {bus_a.done, bus_b.done}, 2'b11);
          n_cmp++;
          if (q.size() == 0) begin
            n_bad++;
            $display("FAIL spurious_done: got done=1 want no pending load (cycle %0d)", cyc);
          end else begin
            pend = q.pop_front();
            chk("done_latency", cyc - pend.cyc, W + 1);
            act = 1'b1;
          end
        end
        if (ea != pa) begin
          chk("slot_len", hold, SD);
          hold = 1;
          chk("en_b_sync", (eb != pb), 1'b1);
          chk("onehot_a", $onehot(ea), 1'b1);
          chk("onehot_b", $onehot(eb), 1'b1);
          for (int i = 0; i < 3; i++)
            if (ea[i]) chk($sformatf("seg_a_d%0d", i), seg_a, cur.seg_a[i]);
          for (int i = 0; i < 2; i++)
            if (eb[i]) chk($sformatf("seg_b_d%0d", i), sb, cur.seg_b[i]);
        end else begin
          hold++;
        end
        pa = ea;
        pb = eb;
      end
      rst_prev = !rst_n;
    end
  end

  initial begin
    repeat (3) @(negedge hwclk);
    rst_n = 1'b1;
    repeat (6 * SD) @(negedge hwclk);

    run(8'd255, 1'b0, 7'h5B, 7'h6D, 7'h6D, 1'b1, 7'h40, 7'h40);
    run(8'd7,   1'b0, 7'h00, 7'h00, 7'h07, 1'b0, 7'h00, 7'h07);
    run(8'd0,   1'b0, 7'h00, 7'h00, 7'h3F, 1'b0, 7'h00, 7'h3F);
    run(8'd100, 1'b0, 7'h06, 7'h3F, 7'h3F, 1'b1, 7'h40, 7'h40);
    run(8'd99,  1'b0, 7'h00, 7'h6F, 7'h6F, 1'b0, 7'h6F, 7'h6F);
    run(8'd205, 1'b0, 7'h5B, 7'h3F, 7'h6D, 1'b1, 7'h40, 7'h40);

    // A load during conversion must be ignored
    issue(8'd5, 1'b0, 7'h00, 7'h00, 7'h6D, 1'b0, 7'h00, 7'h6D);
    @(negedge hwclk);
    load = 1'b0;
    repeat (3) @(negedge hwclk);
    chk("busy_ready", bus_a.ready, 1'b0);
    value = 8'd9;
    load  = 1'b1;
    @(negedge hwclk);
    load = 1'b0;
    settle();

    // Reset in the middle of a conversion aborts it and clears the display
    value = 8'd200;
    load  = 1'b1;
    @(negedge hwclk);
    load = 1'b0;
    repeat (3) @(negedge hwclk);
    rst_n = 1'b0;
    @(negedge hwclk);
    rst_n = 1'b1;
    settle();

    // Back-to-back conversions with load held high
    issue(8'd12, 1'b0, 7'h00, 7'h06, 7'h5B, 1'b0, 7'h06, 7'h5B);
    issue(8'd34, 1'b0, 7'h00, 7'h4F, 7'h66, 1'b0, 7'h4F, 7'h66);
    @(negedge hwclk);
    load = 1'b0;
    settle();

    chk("queue_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
